mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and access sequencer for the 16-word × 32-bit working memory. It shares the memory's single address/data/rw port between:
- port A: the instruction-fetch unit (read-only);
- port B: the load/store unit (read/write).

Each accepted request becomes one two-cycle memory access. The block adds fair round-robin arbitration, out-of-range address protection, and a registered read-data return per requester. It sits between the VM control core and the memory block.

## Interface
Parameters:
- DEPTH, 16, number of implemented memory words; valid addresses are 0..DEPTH-1
- AW, 16, address width
- DW, 32, data width

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- req_a  in  1  port A read request
- addr_a  in  AW  port A address
- gnt_a  out  1  port A request accepted
- rdata_a  out  DW  port A read data
- rvalid_a  out  1  rdata_a/err_a valid
- err_a  out  1  port A address out of range
- req_b  in  1  port B request
- we_b  in  1  port B write enable (1 = write, 0 = read)
- addr_b  in  AW  port B address
- wdata_b  in  DW  port B write data
- gnt_b  out  1  port B request accepted
- rdata_b  out  DW  port B read data
- rvalid_b  out  1  rdata_b/err_b valid
- err_b  out  1  port B address out of range
- mem_addr  out  AW  memory address
- mem_in  out  DW  memory write data
- mem_rw  out  1  memory strobe, 0 = read, 1 = write
- mem_out  in  DW  memory read data, combinational on mem_addr

## Operation
- FSM has two states, IDLE and ACCESS. Reset state is IDLE.
- **IDLE:**
  - Samples req_a and req_b at each posedge.
  - If neither is high, stays in IDLE.
  - Otherwise picks a winner and goes to ACCESS.
- **Arbitration:**
  - A single requester always wins.
  - If both request, the port not granted last wins.
  - A 1-bit last_gnt register is updated on every grant; its reset value is B, so A wins the first tie.
- **On the grant edge**, the following are registered:
  - winner's gnt_x = 1;
  - mem_addr = winner's address;
  - mem_in = wdata_b (port B) or held value (port A);
  - mem_rw = we_b & in_range (port B), or 0 (port A);
  - in_range = (addr < DEPTH), latched with the request.
- **ACCESS** (exactly one cycle):
  - Memory reads combinationally, or commits the write at the closing posedge.
  - The closing posedge captures mem_out, or 0 if out of range, into rdata_x.
  - That same edge sets rvalid_x = 1 and err_x = !in_range, and clears gnt_x and mem_rw.
  - The FSM returns to IDLE.
  - Requests are not sampled in ACCESS.
- **Writes** also produce rvalid_b: rdata_b = 0 and err_b flags an out-of-range write. An out-of-range write never asserts mem_rw.
- **Requester rules:**
  - Hold req/addr/we/wdata stable until gnt is seen.
  - Deassert req before the edge that ends the rvalid cycle; a req still high there is a new request.
- **Reset:**
  - All outputs go to 0 asynchronously: gnt_*, rvalid_*, err_*, rdata_*, mem_addr, mem_in, mem_rw.
  - The FSM returns to IDLE and last_gnt = B.
  - Reset during ACCESS aborts the access: mem_rw drops immediately, no write commits, and no rvalid follows.

## Timing
- Request sampled at edge E0 → gnt_x high E0–E1 (ACCESS) → rvalid_x high E1–E2 (IDLE) → next request sampled at E2.
- Read latency: 2 edges from sample to rvalid. Throughput: one access per 2 cycles.
- Write commit is at E1.
- rvalid_x, gnt_x and err_x are one-cycle pulses.
- rdata_x holds its value until the next completed access on that port.
- Under continuous contention, grants alternate A, B, A, B…, with one grant every 2 cycles. No port waits more than one other access.
- mem_rw is never 1 outside ACCESS.
- mem_addr holds its last value in IDLE.

## Test plan
- **Reset defaults:** rst=0 mid-simulation → all outputs 0 immediately. After release, the first tie between A and B → gnt_a.
- **Write then read on port B:**
  - write 0xDEADBEEF to addr 5 → mem_rw=1 for exactly one cycle, and rvalid_b with err_b=0.
  - read addr 5 → rdata_b=0xDEADBEEF two edges after sampling.
- **Contention:** req_a and req_b held high for 8 cycles, with addresses 3 and 7 → grants A, B, A, B. rvalid pulses alternate every 2 cycles, and rdata matches the memory words at 3 and 7.
- **Out of range:**
  - B write to addr 16 with 0x12345678 → mem_rw stays 0, err_b=1, and word 0 is unchanged.
  - A read of addr 0xFFFF → rdata_a=0, err_a=1.
- **Reset mid-access:** assert rst during the ACCESS cycle of a B write of 0xA5A5A5A5 to addr 2 → no rvalid_b, and a later read of addr 2 does not return 0xA5A5A5A5.
- **Held request:** req_a held high through the rvalid cycle → a second gnt_a on the next IDLE sample, and no grant while in ACCESS.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single address/data/rw port of the 16 x 32 working memory
// between the instruction-fetch unit (port A, read-only) and the load/store
// unit (port B, read/write). Each accepted request becomes one two-cycle
// access:
//   E0: request sampled in IDLE, grant and memory controls registered
//   E1: ACCESS closes, read data / error / rvalid registered, back to IDLE
// Ties go to the port that was not granted last. Addresses at or above DEPTH
// never reach the memory as writes and return zero data with err set.
//
// Ports
//   clk, rst           clock (posedge), asynchronous active-low reset
//   req_a, addr_a      port A read request
//   gnt_a              port A accepted (one-cycle pulse, ACCESS cycle)
//   rdata_a, rvalid_a  port A read data, valid pulse on the cycle after gnt_a
//   err_a              port A address was out of range (with rvalid_a)
//   req_b, we_b,       port B request, write enable, address, write data
//   addr_b, wdata_b
//   gnt_b, rdata_b,    port B accept / data / valid / error, as for port A;
//   rvalid_b, err_b    writes also return rvalid_b with rdata_b = 0
//   mem_addr, mem_in   memory address and write data (held between accesses)
//   mem_rw             memory write strobe, only ever high during ACCESS
//   mem_out            memory read data, combinational on mem_addr
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DEPTH = 16,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req_a,
    input  logic [AW-1:0] addr_a,
    output logic          gnt_a,
    output logic [DW-1:0] rdata_a,
    output logic          rvalid_a,
    output logic          err_a,

    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic [DW-1:0] rdata_b,
    output logic          rvalid_b,
    output logic          err_b,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    output logic          mem_rw,
    input  logic [DW-1:0] mem_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

    state_t        state_q, state_d;
    logic          last_b_q, last_b_d;     // 1: port B received the last grant
    logic          sel_b_q, sel_b_d;       // port owning the access in flight
    logic          wr_q, wr_d;             // access in flight is a port B write
    logic          in_range_q, in_range_d;

    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d;
    logic [DW-1:0] rdata_b_q, rdata_b_d;
    logic          rvalid_a_q, rvalid_a_d;
    logic          rvalid_b_q, rvalid_b_d;
    logic          err_a_q, err_a_d;
    logic          err_b_q, err_b_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_in_q, mem_in_d;
    logic          mem_rw_q, mem_rw_d;

    logic          win_b;
    logic [AW-1:0] win_addr;
    logic          win_in_range;
    logic [DW-1:0] ret_data;

    always_comb begin
        state_d      = state_q;
        last_b_d     = last_b_q;
        sel_b_d      = sel_b_q;
        wr_d         = wr_q;
        in_range_d   = in_range_q;
        gnt_a_d      = gnt_a_q;
        gnt_b_d      = gnt_b_q;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        mem_addr_d   = mem_addr_q;
        mem_in_d     = mem_in_q;
        mem_rw_d     = mem_rw_q;
        // Response flags are one-cycle pulses; only the ACCESS close sets them.
        rvalid_a_d   = 1'b0;
        rvalid_b_d   = 1'b0;
        err_a_d      = 1'b0;
        err_b_d      = 1'b0;

        // B wins when it is alone, or on a tie when A was granted last.
        win_b        = req_b & (~req_a | ~last_b_q);
        win_addr     = win_b ? addr_b : addr_a;
        win_in_range = (win_addr < LIMIT);
        // Writes and out-of-range accesses return zero data.
        ret_data     = (in_range_q && !wr_q) ? mem_out : '0;

        unique case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d    = ACCESS;
                    last_b_d   = win_b;
                    sel_b_d    = win_b;
                    wr_d       = win_b & we_b;
                    in_range_d = win_in_range;
                    gnt_a_d    = ~win_b;
                    gnt_b_d    = win_b;
                    mem_addr_d = win_addr;
                    if (win_b) begin
                        mem_in_d = wdata_b;
                    end
                    // An out-of-range write must never strobe the memory.
                    mem_rw_d   = win_b & we_b & win_in_range;
                end
            end

            ACCESS: begin
                state_d  = IDLE;
                gnt_a_d  = 1'b0;
                gnt_b_d  = 1'b0;
                mem_rw_d = 1'b0;
                if (sel_b_q) begin
                    rdata_b_d  = ret_data;
                    rvalid_b_d = 1'b1;
                    err_b_d    = ~in_range_q;
                end else begin
                    rdata_a_d  = ret_data;
                    rvalid_a_d = 1'b1;
                    err_a_d    = ~in_range_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset clears everything asynchronously; an access caught by reset is
    // dropped with no write commit and no response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            sel_b_q    <= 1'b0;
            wr_q       <= 1'b0;
            in_range_q <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
            mem_rw_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            sel_b_q    <= sel_b_d;
            wr_q       <= wr_d;
            in_range_q <= in_range_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            mem_addr_q <= mem_addr_d;
            mem_in_q   <= mem_in_d;
            mem_rw_q   <= mem_rw_d;
        end
    end

    assign gnt_a    = gnt_a_q;
    assign rdata_a  = rdata_a_q;
    assign rvalid_a = rvalid_a_q;
    assign err_a    = err_a_q;
    assign gnt_b    = gnt_b_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_b = rvalid_b_q;
    assign err_b    = err_b_q;
    assign mem_addr = mem_addr_q;
    assign mem_in   = mem_in_q;
    assign mem_rw   = mem_rw_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. A 16-word memory sits behind the arbiter; a separate
// reference memory and a "who was granted last" flag predict every grant and
// every response at transaction level. Directed steps come first, followed by
// a randomized run where a losing requester keeps its request held.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, we_b;
    logic [15:0] addr_a, addr_b;
    logic [31:0] wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, mem_rw;
    logic [31:0] rdata_a, rdata_b, mem_in, mem_out;
    logic [15:0] mem_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH(16), .AW(16), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a), .rdata_a(rdata_a),
        .rvalid_a(rvalid_a), .err_a(err_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b), .err_b(err_b),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_rw(mem_rw), .mem_out(mem_out)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0011;
    endfunction

    // Memory block behind the arbiter; out-of-range reads return junk so the
    // arbiter's zeroing is visible.
    logic [31:0] mem [16];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (mem_rw && mem_addr < 16'd16) begin
            mem[mem_addr[3:0]] <= mem_in;
        end
    end
    assign mem_out = (mem_addr < 16'd16) ? mem[mem_addr[3:0]] : 32'hBAD0_BAD0;

    // Reference state
    logic [31:0] m_mem [16];
    bit          m_last_b;
    logic [31:0] exp_rd_a, exp_rd_b;
    logic [15:0] exp_mem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt_a"}, gnt_a, 0);
        chk({tag, ".gnt_b"}, gnt_b, 0);
        chk({tag, ".rvalid_a"}, rvalid_a, 0);
        chk({tag, ".rvalid_b"}, rvalid_b, 0);
        chk({tag, ".err_a"}, err_a, 0);
        chk({tag, ".err_b"}, err_b, 0);
        chk({tag, ".rdata_a"}, rdata_a, 0);
        chk({tag, ".rdata_b"}, rdata_b, 0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".mem_in"}, mem_in, 0);
        chk({tag, ".mem_rw"}, mem_rw, 0);
    endtask

    task automatic model_reset();
        m_last_b     = 1'b1;
        exp_rd_a     = '0;
        exp_rd_b     = '0;
        exp_mem_addr = '0;
    endtask

    task automatic idle_cycle();
        req_a = 0;
        req_b = 0;
        tick();
        chk("idle.gnt_a", gnt_a, 0);
        chk("idle.gnt_b", gnt_b, 0);
        chk("idle.rvalid_a", rvalid_a, 0);
        chk("idle.rvalid_b", rvalid_b, 0);
        chk("idle.mem_rw", mem_rw, 0);
        chk("idle.mem_addr", mem_addr, exp_mem_addr);
    endtask

    // One arbitration round from IDLE: grant edge, then the closing edge.
    // Request inputs stay as driven, so a held request is resampled next.
    task automatic xact(input bit ra, input logic [15:0] aa, input bit rb, input bit wb,
                        input logic [15:0] ab, input logic [31:0] db, output bit saw_gnt_b);
        bit          w_b, wr, inr;
        logic [15:0] ad;
        logic [31:0] rd;
        req_a = ra; addr_a = aa;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        tick();
        w_b      = (ra && rb) ? !m_last_b : rb;
        m_last_b = w_b;
        ad       = w_b ? ab : aa;
        inr      = ad < 16'd16;
        wr       = w_b && wb;
        chk("grant.gnt_a", gnt_a, !w_b);
        chk("grant.gnt_b", gnt_b, w_b);
        chk("grant.mem_addr", mem_addr, ad);
        chk("grant.mem_rw", mem_rw, wr && inr);
        chk("grant.rvalid_a", rvalid_a, 0);
        chk("grant.rvalid_b", rvalid_b, 0);
        if (wr) chk("grant.mem_in", mem_in, db);
        saw_gnt_b = gnt_b;
        tick();
        rd = (inr && !wr) ? m_mem[ad[3:0]] : 32'h0;
        if (wr && inr) m_mem[ad[3:0]] = db;
        if (w_b) exp_rd_b = rd; else exp_rd_a = rd;
        exp_mem_addr = ad;
        chk("resp.gnt_a", gnt_a, 0);
        chk("resp.gnt_b", gnt_b, 0);
        chk("resp.mem_rw", mem_rw, 0);
        chk("resp.rvalid_a", rvalid_a, !w_b);
        chk("resp.rvalid_b", rvalid_b, w_b);
        chk("resp.err_a", err_a, !w_b && !inr);
        chk("resp.err_b", err_b, w_b && !inr);
        chk("resp.rdata_a", rdata_a, exp_rd_a);
        chk("resp.rdata_b", rdata_b, exp_rd_b);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 16'($urandom_range(16, 65535));
        return 16'($urandom_range(0, 15));
    endfunction

    initial begin
        bit          g;
        bit          pend_a, pend_b, ra, rb, wb;
        logic [15:0] aa, ab;
        logic [31:0] db;

        rst = 0; mem_clr = 1;
        req_a = 0; req_b = 0; we_b = 0; addr_a = 0; addr_b = 0; wdata_b = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = init_word(i);
        model_reset();
        repeat (3) tick();
        chk_zero("por");
        mem_clr = 0;
        rst = 1;
        tick();

        // Port B write then read back
        xact(0, 0, 1, 1, 16'd5, 32'hDEAD_BEEF, g);
        xact(0, 0, 1, 0, 16'd5, 32'h0, g);
        chk("wr_rd.rdata_b", rdata_b, 32'hDEAD_BEEF);

        // Continuous contention: A, B, A, B
        for (int k = 0; k < 4; k++) begin
            xact(1, 16'd3, 1, 0, 16'd7, 32'h0, g);
            chk("contend.order_b", g, 32'(k % 2));
        end
        chk("contend.rdata_a", rdata_a, init_word(3));
        chk("contend.rdata_b", rdata_b, init_word(7));

        // Out-of-range write and read
        xact(0, 0, 1, 1, 16'd16, 32'h1234_5678, g);
        xact(1, 16'd0, 0, 0, 0, 0, g);
        chk("oor.word0_kept", rdata_a, init_word(0));
        xact(1, 16'hFFFF, 0, 0, 0, 0, g);
        chk("oor.err_a", err_a, 1);
        chk("oor.rdata_a", rdata_a, 0);

        // req_a held through the response cycle is a second request
        xact(1, 16'd9, 0, 0, 0, 0, g);
        xact(1, 16'd9, 0, 0, 0, 0, g);
        chk("held.second_gnt_b", g, 0);
        idle_cycle();

        // Reset in the ACCESS cycle of a B write
        req_b = 1; we_b = 1; addr_b = 16'd2; wdata_b = 32'hA5A5_A5A5;
        tick();
        chk("rst_mid.gnt_b", gnt_b, 1);
        chk("rst_mid.mem_rw", mem_rw, 1);
        #2 rst = 0;
        #1 chk_zero("rst_mid");
        req_b = 0; we_b = 0;
        tick();
        chk("rst_mid.no_rvalid_b", rvalid_b, 0);
        rst = 1;
        model_reset();
        tick();
        chk("rst_mid.idle_rvalid_b", rvalid_b, 0);

        // First tie after reset goes to A
        xact(1, 16'd4, 1, 0, 16'd2, 0, g);
        chk("first_tie.gnt_b", g, 0);
        xact(0, 0, 1, 0, 16'd2, 0, g);
        chk("rst_mid.no_commit", rdata_b == 32'hA5A5_A5A5, 0);

        // Randomized run; a loser keeps its request until granted
        pend_a = 0; pend_b = 0;
        aa = 0; ab = 0; wb = 0; db = 0;
        for (int it = 0; it < 80; it++) begin
            ra = pend_a ? 1'b1 : ($urandom_range(0, 2) != 0);
            rb = pend_b ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (!pend_a) aa = rand_addr();
            if (!pend_b) begin
                ab = rand_addr();
                wb = $urandom_range(0, 1) == 1;
                db = $urandom;
            end
            if (!ra && !rb) begin
                idle_cycle();
            end else begin
                xact(ra, aa, rb, wb, ab, db, g);
                pend_a = ra && g;
                pend_b = rb && !g;
            end
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
